// File: rtl/semaphore_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// semaphore_sequencer_pkg
// Shared definitions for the traffic-light sequencer:
//   - state_t      : phase enumeration; the encoding is the code shown on
//                    display[11:8]
//   - DIR_*        : direction remembered across a pedestrian walk phase
//   - LED_*        : bit positions inside the 16-bit lamp word
//   - DISP_*       : nibble positions inside the 32-bit display word
// ---------------------------------------------------------------------------
package semaphore_sequencer_pkg;

   typedef enum logic [3:0] {
      NS_GREEN  = 4'd0,
      NS_YELLOW = 4'd1,
      ALLRED_A  = 4'd2,
      EW_GREEN  = 4'd3,
      EW_YELLOW = 4'd4,
      ALLRED_B  = 4'd5,
      PED_WALK  = 4'd6
   } state_t;

   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

   localparam int LED_NS_GREEN  = 0;
   localparam int LED_NS_YELLOW = 1;
   localparam int LED_NS_RED    = 2;
   localparam int LED_EW_GREEN  = 3;
   localparam int LED_EW_YELLOW = 4;
   localparam int LED_EW_RED    = 5;
   localparam int LED_WALK      = 6;
   localparam int LED_PENDING   = 7;

   localparam int DISP_UNITS_LSB = 0;
   localparam int DISP_TENS_LSB  = 4;
   localparam int DISP_STATE_LSB = 8;

endpackage

// File: rtl/semaphore_sequencer_bin2bcd99.sv
// ---------------------------------------------------------------------------
// bin2bcd99
// Purely combinational two-digit binary-to-BCD converter for values 0..99.
// Ports:
//   bin   in  7  binary value, 0..99
//   tens  out 4  BCD tens digit
//   units out 4  BCD units digit
// ---------------------------------------------------------------------------
module bin2bcd99 (
   input  logic [6:0] bin,
   output logic [3:0] tens,
   output logic [3:0] units
);

   assign tens  = 4'(bin / 7'd10);
   assign units = 4'(bin - (7'(tens) * 7'd10));

endmodule

// File: rtl/semaphore_sequencer.sv
// ---------------------------------------------------------------------------
// semaphore_sequencer
// Two-road traffic-light controller with a pedestrian walk phase.
// A prescaler produces a one-cycle tick every CLK_HZ cycles; each tick counts
// the remaining seconds of the current phase down, and the tick that finds
// one second left moves to the next phase with its full duration loaded.
// A synchronized press of the pedestrian button sets a pending flag that
// inserts PED_WALK after the next all-red clearance.
// Ports:
//   clk        in  1   system clock, rising edge
//   reset_n    in  1   asynchronous active-low reset
//   ped_req_n  in  1   pedestrian button, active-low, asynchronous
//   hold       in  1   freeze prescaler, countdown and phase while high
//   led        out 16  lamp word (see LED_* in the package)
//   display    out 32  [7:0] remaining seconds in BCD, [11:8] state code
// ---------------------------------------------------------------------------
module semaphore_sequencer
   import semaphore_sequencer_pkg::*;
#(
   parameter int CLK_HZ   = 50_000_000,
   parameter int GREEN_S  = 20,
   parameter int YELLOW_S = 3,
   parameter int ALLRED_S = 1,
   parameter int WALK_S   = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ped_req_n,
   input  logic        hold,
   output logic [15:0] led,
   output logic [31:0] display
);

   localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

   state_t        state, state_nx;
   logic [6:0]    remaining, remaining_nx;
   logic [PW-1:0] presc, presc_nx;
   logic          pending, pending_nx;
   logic          next_dir, next_dir_nx;
   logic          sync1, sync2, sync_prev;
   logic          tick;
   logic          ped_fall;
   logic [3:0]    bcd_tens, bcd_units;

   function automatic logic [6:0] phase_len(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   return 7'(GREEN_S);
         NS_YELLOW, EW_YELLOW: return 7'(YELLOW_S);
         ALLRED_A, ALLRED_B:   return 7'(ALLRED_S);
         PED_WALK:             return 7'(WALK_S);
         default:              return 7'(GREEN_S);
      endcase
   endfunction

   // Button path: two synchronizer flops plus one delayed copy for edge
   // detection. All idle high so reset never fabricates a press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync1     <= ped_req_n;
         sync2     <= sync1;
         sync_prev <= sync2;
      end
   end

   assign ped_fall = sync_prev & ~sync2;
   assign tick     = !hold && (presc == PRESC_MAX);

   // Phase state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= NS_GREEN;
         remaining <= 7'(GREEN_S);
         presc     <= '0;
         pending   <= 1'b0;
         next_dir  <= DIR_EW;
      end else begin
         state     <= state_nx;
         remaining <= remaining_nx;
         presc     <= presc_nx;
         pending   <= pending_nx;
         next_dir  <= next_dir_nx;
      end
   end

   // Next-state: prescaler, countdown, phase sequencing, request capture
   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      presc_nx     = presc;
      pending_nx   = pending;
      next_dir_nx  = next_dir;

      if (!hold)
         presc_nx = tick ? '0 : presc + 1'b1;

      if (tick) begin
         if (remaining > 7'd1) begin
            remaining_nx = remaining - 7'd1;
         end else begin
            case (state)
               NS_GREEN:  state_nx = NS_YELLOW;
               NS_YELLOW: state_nx = ALLRED_A;
               ALLRED_A: begin
                  if (pending) begin
                     state_nx    = PED_WALK;
                     next_dir_nx = DIR_EW;
                  end else begin
                     state_nx = EW_GREEN;
                  end
               end
               EW_GREEN:  state_nx = EW_YELLOW;
               EW_YELLOW: state_nx = ALLRED_B;
               ALLRED_B: begin
                  if (pending) begin
                     state_nx    = PED_WALK;
                     next_dir_nx = DIR_NS;
                  end else begin
                     state_nx = NS_GREEN;
                  end
               end
               PED_WALK:  state_nx = (next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
               default:   state_nx = NS_GREEN;
            endcase
            remaining_nx = phase_len(state_nx);
         end
      end

      // Entering the walk consumes the request and wins over a press that
      // lands in the same cycle; presses during the walk are dropped.
      if (state_nx == PED_WALK && state != PED_WALK)
         pending_nx = 1'b0;
      else if (ped_fall && state != PED_WALK)
         pending_nx = 1'b1;
   end

   // Lamp decode: only green/yellow phases light a non-red lamp, and each of
   // those lights exactly one road, so the roads can never conflict.
   always_comb begin
      led = '0;
      case (state)
         NS_GREEN: begin
            led[LED_NS_GREEN] = 1'b1;
            led[LED_EW_RED]   = 1'b1;
         end
         NS_YELLOW: begin
            led[LED_NS_YELLOW] = 1'b1;
            led[LED_EW_RED]    = 1'b1;
         end
         EW_GREEN: begin
            led[LED_EW_GREEN] = 1'b1;
            led[LED_NS_RED]   = 1'b1;
         end
         EW_YELLOW: begin
            led[LED_EW_YELLOW] = 1'b1;
            led[LED_NS_RED]    = 1'b1;
         end
         PED_WALK: begin
            led[LED_NS_RED] = 1'b1;
            led[LED_EW_RED] = 1'b1;
            led[LED_WALK]   = 1'b1;
         end
         default: begin
            led[LED_NS_RED] = 1'b1;
            led[LED_EW_RED] = 1'b1;
         end
      endcase
      led[LED_PENDING] = pending;
   end

   bin2bcd99 u_bcd (
      .bin   (remaining),
      .tens  (bcd_tens),
      .units (bcd_units)
   );

   always_comb begin
      display = '0;
      display[DISP_UNITS_LSB +: 4] = bcd_units;
      display[DISP_TENS_LSB  +: 4] = bcd_tens;
      display[DISP_STATE_LSB +: 4] = state;
   end

endmodule

// File: tb/tb_semaphore_sequencer.sv
module tb_semaphore_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ped_req_n;
   logic        hold;
   logic [15:0] led;
   logic [31:0] display;

   int total = 0;
   int bad   = 0;

   semaphore_sequencer #(
      .CLK_HZ   (4),
      .GREEN_S  (3),
      .YELLOW_S (2),
      .ALLRED_S (1),
      .WALK_S   (2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ped_req_n (ped_req_n),
      .hold      (hold),
      .led       (led),
      .display   (display)
   );

   always #5 clk = ~clk;

   // Both roads must never show green/yellow at the same time.
   always @(negedge clk) begin
      total++;
      assert (!((led[0] | led[1]) && (led[3] | led[4])))
      else begin
         bad++;
         $display("FAIL lamp_conflict led=%h required no NS/EW go overlap", led);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts samples spent in state 'code', starting with the current one.
   task automatic wait_dwell(input logic [3:0] code, output int n);
      n = 0;
      while (display[11:8] == code && n < 200) begin
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      ped_req_n = 1'b1;
      hold      = 1'b0;
      repeat (3) step();
      total++; if (led !== 16'h0021) begin bad++; $display("FAIL reset_led got=%h want=%h", led, 16'h0021); end
      total++; if (display !== 32'h0000_0003) begin bad++; $display("FAIL reset_display got=%h want=%h", display, 32'h3); end
      reset_n = 1'b1;
      total++; if (led !== 16'h0021) begin bad++; $display("FAIL release_led got=%h want=%h", led, 16'h0021); end
   endtask

   task automatic test_free_run();
      logic [3:0]  codes [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      logic [15:0] leds  [6] = '{16'h0021, 16'h0022, 16'h0024, 16'h000C, 16'h0014, 16'h0024};
      logic [7:0]  rems  [6] = '{8'h03, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01};
      int          dwell [6] = '{12, 8, 4, 12, 8, 4};
      int n;
      int sum = 0;
      for (int i = 0; i < 6; i++) begin
         total++; if (display[11:8] !== codes[i]) begin bad++; $display("FAIL free_state[%0d] got=%0d want=%0d", i, display[11:8], codes[i]); end
         total++; if (led !== leds[i]) begin bad++; $display("FAIL free_led[%0d] got=%h want=%h", i, led, leds[i]); end
         total++; if (display[7:0] !== rems[i]) begin bad++; $display("FAIL free_remaining[%0d] got=%h want=%h", i, display[7:0], rems[i]); end
         wait_dwell(codes[i], n);
         sum += n;
         total++; if (n !== dwell[i]) begin bad++; $display("FAIL free_dwell[%0d] got=%0d want=%0d", i, n, dwell[i]); end
      end
      total++; if (display[11:8] !== 4'd0 || sum !== 48) begin bad++; $display("FAIL free_period state=%0d sum=%0d want state 0 sum 48", display[11:8], sum); end
   endtask

   task automatic test_ped_button();
      int n;
      ped_req_n = 1'b0;
      step(); step();
      total++; if (led[7] !== 1'b0) begin bad++; $display("FAIL ped_early got=%b want=0", led[7]); end
      step();
      total++; if (led !== 16'h00A1) begin bad++; $display("FAIL ped_pending got=%h want=%h", led, 16'h00A1); end
      ped_req_n = 1'b1;
      wait_dwell(4'd0, n);
      wait_dwell(4'd1, n);
      total++; if (n !== 8) begin bad++; $display("FAIL ped_yellow_dwell got=%0d want=8", n); end
      wait_dwell(4'd2, n);
      total++; if (n !== 4) begin bad++; $display("FAIL ped_allred_dwell got=%0d want=4", n); end
      total++; if (led !== 16'h0064) begin bad++; $display("FAIL walk_led got=%h want=%h", led, 16'h0064); end
      total++; if (display !== 32'h0000_0602) begin bad++; $display("FAIL walk_display got=%h want=%h", display, 32'h602); end
      wait_dwell(4'd6, n);
      total++; if (n !== 8) begin bad++; $display("FAIL walk_dwell got=%0d want=8", n); end
      total++; if (display[11:8] !== 4'd3 || led !== 16'h000C) begin bad++; $display("FAIL after_walk state=%0d led=%h want 3/000c", display[11:8], led); end
   endtask

   task automatic test_press_in_walk();
      int n;
      ped_req_n = 1'b0;
      repeat (3) step();
      ped_req_n = 1'b1;
      total++; if (led !== 16'h008C) begin bad++; $display("FAIL ew_pending got=%h want=%h", led, 16'h008C); end
      wait_dwell(4'd3, n);
      wait_dwell(4'd4, n);
      total++; if (n !== 8) begin bad++; $display("FAIL ew_yellow_dwell got=%0d want=8", n); end
      total++; if (led !== 16'h00A4) begin bad++; $display("FAIL allred_b_led got=%h want=%h", led, 16'h00A4); end
      wait_dwell(4'd5, n);
      total++; if (display[11:8] !== 4'd6 || led !== 16'h0064) begin bad++; $display("FAIL walk_b state=%0d led=%h want 6/0064", display[11:8], led); end
      ped_req_n = 1'b0;
      repeat (3) step();
      ped_req_n = 1'b1;
      repeat (2) step();
      total++; if (led !== 16'h0064) begin bad++; $display("FAIL walk_press_ignored got=%h want=%h", led, 16'h0064); end
      wait_dwell(4'd6, n);
      total++; if (display[11:8] !== 4'd0 || led !== 16'h0021) begin bad++; $display("FAIL walk_to_ns state=%0d led=%h want 0/0021", display[11:8], led); end
      wait_dwell(4'd0, n);
      total++; if (n !== 12) begin bad++; $display("FAIL ns_dwell_after_walk got=%0d want=12", n); end
      wait_dwell(4'd1, n);
      wait_dwell(4'd2, n);
      total++; if (display[11:8] !== 4'd3 || led !== 16'h000C) begin bad++; $display("FAIL no_second_walk state=%0d led=%h want 3/000c", display[11:8], led); end
   endtask

   task automatic test_hold();
      int n;
      repeat (6) step();
      total++; if (display !== 32'h0000_0302 || led !== 16'h000C) begin bad++; $display("FAIL hold_pre display=%h led=%h want 302/000c", display, led); end
      hold = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         total++; if (display !== 32'h0000_0302 || led !== 16'h000C) begin bad++; $display("FAIL hold_frozen[%0d] display=%h led=%h want 302/000c", i, display, led); end
      end
      hold = 1'b0;
      wait_dwell(4'd3, n);
      total++; if (n !== 6) begin bad++; $display("FAIL hold_resume_dwell got=%0d want=6", n); end
      total++; if (display[11:8] !== 4'd4 || led !== 16'h0014) begin bad++; $display("FAIL hold_next state=%0d led=%h want 4/0014", display[11:8], led); end
   endtask

   task automatic test_async_reset();
      int n;
      ped_req_n = 1'b0;
      repeat (3) step();
      ped_req_n = 1'b1;
      total++; if (led !== 16'h0094) begin bad++; $display("FAIL yellow_pending got=%h want=%h", led, 16'h0094); end
      #3;
      reset_n = 1'b0;
      #1;
      total++; if (led !== 16'h0021) begin bad++; $display("FAIL async_reset_led got=%h want=%h", led, 16'h0021); end
      total++; if (display !== 32'h0000_0003) begin bad++; $display("FAIL async_reset_display got=%h want=%h", display, 32'h3); end
      repeat (2) step();
      total++; if (led !== 16'h0021 || display !== 32'h0000_0003) begin bad++; $display("FAIL reset_held led=%h display=%h want 0021/3", led, display); end
      reset_n = 1'b1;
      wait_dwell(4'd0, n);
      total++; if (n !== 12) begin bad++; $display("FAIL restart_dwell got=%0d want=12", n); end
      wait_dwell(4'd1, n);
      wait_dwell(4'd2, n);
      total++; if (display[11:8] !== 4'd3 || led !== 16'h000C) begin bad++; $display("FAIL pending_lost state=%0d led=%h want 3/000c", display[11:8], led); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_ped_button();
      test_press_in_walk();
      test_hold();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
